// File: rtl/up_counter_mod.sv
// -----------------------------------------------------------------------------
// up_counter_mod
//   Modulo-MODULUS up counter with synchronous clear, parallel load, count
//   enable, registered terminal-count decode, wrap pulse, sticky overflow flag
//   and a load-range error pulse. The sequence is 0 .. MODULUS-1. Intended as a
//   reusable timebase or event counter: cascade through `wrap`, or poll `ovf`.
//
// Parameters
//   WIDTH    count register width (default 4)
//   MODULUS  sequence length, legal range 2 .. 2**WIDTH (default 16)
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   en        in   count enable
//   clear     in   synchronous clear to 0 (highest priority)
//   load      in   synchronous parallel load (beats en)
//   load_val  in   load value; values above MODULUS-1 load 0 and flag load_err
//   ovf_clr   in   clears the sticky overflow flag (a same-edge wrap wins)
//   count     out  current count
//   tc        out  high while count == MODULUS-1
//   wrap      out  one-cycle pulse in the cycle count has just wrapped to 0
//   ovf       out  sticky overflow flag, set on every wrap
//   load_err  out  one-cycle pulse after an out-of-range load
//
// Optional feature (macro UP_COUNTER_MOD_CMP_EN)
//   Adds input cmp_val[WIDTH-1:0] and output cmp_hit, a registered flag that
//   is high exactly in the cycles where count == cmp_val.
//
// All outputs are registered; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module up_counter_mod #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
`ifdef UP_COUNTER_MOD_CMP_EN
  input  logic [WIDTH-1:0] cmp_val,
  output logic             cmp_hit,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf,
  output logic             load_err
);

  // Reject an impossible modulus while elaborating rather than silently
  // building a counter that can never reach its terminal value.
  localparam longint unsigned MAX_MODULUS = 64'd1 << WIDTH;

  if (MODULUS < 2 || longint'(MODULUS) > longint'(MAX_MODULUS)) begin : g_bad_modulus
    $error("up_counter_mod: MODULUS=%0d outside legal range 2..2**WIDTH", MODULUS);
  end

  // Everything is handled one bit wider than the register so that the
  // MODULUS = 2**WIDTH case compares against MODULUS-1 exactly, without
  // relying on the natural carry out of the count register.
  localparam logic [WIDTH:0] LAST = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE  = (WIDTH + 1)'(1);

  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] load_ext;
  logic [WIDTH:0] inc_ext;
  logic [WIDTH:0] count_nxt;
  logic           wrap_nxt;
  logic           load_err_nxt;
  logic           ovf_nxt;

  assign count_ext = {1'b0, count};
  assign load_ext  = {1'b0, load_val};
  assign inc_ext   = count_ext + ONE;

  // Next-state decode in priority order: clear, load, en, hold.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch can be inferred; blocking '=' is
  // correct here because this is combinational logic, not state.
  always_comb begin
    count_nxt    = count_ext;
    wrap_nxt     = 1'b0;
    load_err_nxt = 1'b0;

    if (clear) begin
      count_nxt = '0;
    end else if (load) begin
      if (load_ext <= LAST) begin
        count_nxt = load_ext;
      end else begin
        count_nxt    = '0;
        load_err_nxt = 1'b1;
      end
    end else if (en) begin
      if (count_ext == LAST) begin
        count_nxt = '0;
        wrap_nxt  = 1'b1;
      end else begin
        count_nxt = inc_ext;
      end
    end
  end

  // A wrap on the same edge as ovf_clr keeps the flag set.
  assign ovf_nxt = wrap_nxt | (ovf & ~ovf_clr);

  // tc, wrap and load_err are decoded from the next count so they line up
  // with the cycle in which that count becomes visible.
  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      tc       <= 1'b0;
      wrap     <= 1'b0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= count_nxt[WIDTH-1:0];
      tc       <= (count_nxt == LAST);
      wrap     <= wrap_nxt;
      ovf      <= ovf_nxt;
      load_err <= load_err_nxt;
    end
  end

`ifdef UP_COUNTER_MOD_CMP_EN
  // cmp_val is sampled at the edge, so a change shows up one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_hit <= 1'b0;
    end else begin
      cmp_hit <= (count_nxt == {1'b0, cmp_val});
    end
  end
`endif

endmodule

// File: tb/tb_up_counter_mod.sv
// -----------------------------------------------------------------------------
// tb_up_counter_mod
//   Self-checking bench for up_counter_mod with WIDTH=4, MODULUS=10.
//   A directed vector table, hand-written multi-cycle sequences (free run,
//   enable gating, asynchronous reset mid-count) and a randomized phase are
//   compared against a behavioural model that follows the counting rules
//   with plain modular arithmetic.
// -----------------------------------------------------------------------------
module tb_up_counter_mod;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             ovf_clr;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             ovf;
  logic             load_err;
`ifdef UP_COUNTER_MOD_CMP_EN
  logic [WIDTH-1:0] cmp_val;
  logic             cmp_hit;
`endif

  up_counter_mod #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .ovf_clr  (ovf_clr),
`ifdef UP_COUNTER_MOD_CMP_EN
    .cmp_val  (cmp_val),
    .cmp_hit  (cmp_hit),
`endif
    .count    (count),
    .tc       (tc),
    .wrap     (wrap),
    .ovf      (ovf),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference state.
  int m_count;
  int m_wrap;
  int m_ovf;
  int m_lerr;
  int m_cmp_val;
  int m_cmp;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_wrap  = 0;
    m_ovf   = 0;
    m_lerr  = 0;
    m_cmp   = 0;
  endtask

  task automatic model_edge(input int c, input int l, input int lv, input int e, input int oc);
    m_wrap = 0;
    m_lerr = 0;
    if (c != 0) begin
      m_count = 0;
    end else if (l != 0) begin
      if (lv < MODULUS) begin
        m_count = lv;
      end else begin
        m_count = 0;
        m_lerr  = 1;
      end
    end else if (e != 0) begin
      m_wrap  = (m_count + 1 == MODULUS) ? 1 : 0;
      m_count = (m_count + 1) % MODULUS;
    end
    if (m_wrap != 0)    m_ovf = 1;
    else if (oc != 0)   m_ovf = 0;
    m_cmp = (m_count == m_cmp_val) ? 1 : 0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, " count"},    int'(count),    m_count);
    check({tag, " tc"},       int'(tc),       (m_count == MODULUS - 1) ? 1 : 0);
    check({tag, " wrap"},     int'(wrap),     m_wrap);
    check({tag, " ovf"},      int'(ovf),      m_ovf);
    check({tag, " load_err"}, int'(load_err), m_lerr);
`ifdef UP_COUNTER_MOD_CMP_EN
    check({tag, " cmp_hit"},  int'(cmp_hit),  m_cmp);
`endif
  endtask

  // Called at posedge+1: drive inputs, let one edge happen, sample at +1.
  task automatic step(input logic c, input logic l, input logic [WIDTH-1:0] lv,
                      input logic e, input logic oc);
    clear    = c;
    load     = l;
    load_val = lv;
    en       = e;
    ovf_clr  = oc;
    @(posedge clk);
    #1;
    model_edge(int'(c), int'(l), int'(lv), int'(e), int'(oc));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             ovf_clr;
    int               exp_count;
    logic             exp_tc;
    logic             exp_wrap;
    logic             exp_ovf;
    logic             exp_lerr;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // clr ld  lv    en  oc   cnt tc  wrap ovf lerr
    vecs[0]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'd7,  1'b1, 1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 9, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 9, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 4'd9,  1'b0, 1'b0, 9, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 4'd5,  1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 4'd9,  1'b0, 1'b0, 9, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 4'd15, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 4'd10, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0};

    reset    = 1'b1;
    en       = 1'b0;
    clear    = 1'b0;
    load     = 1'b0;
    load_val = '0;
    ovf_clr  = 1'b0;
`ifdef UP_COUNTER_MOD_CMP_EN
    cmp_val  = 4'd4;
`endif
    m_cmp_val = 4;
    model_reset();

    // Reset state while reset is held.
    #2;
    compare_model("reset");
    #10;
    reset = 1'b0;
    @(posedge clk);
    #1;
    compare_model("post_reset_idle");

    // Directed vector table.
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].clear, vecs[i].load, vecs[i].load_val, vecs[i].en, vecs[i].ovf_clr);
      check($sformatf("vec%0d count", i),    int'(count),    vecs[i].exp_count);
      check($sformatf("vec%0d tc", i),       int'(tc),       int'(vecs[i].exp_tc));
      check($sformatf("vec%0d wrap", i),     int'(wrap),     int'(vecs[i].exp_wrap));
      check($sformatf("vec%0d ovf", i),      int'(ovf),      int'(vecs[i].exp_ovf));
      check($sformatf("vec%0d load_err", i), int'(load_err), int'(vecs[i].exp_lerr));
    end

    // Free run: 25 enabled cycles, wrap every MODULUS cycles.
    do_reset();
    begin
      int n_wraps = 0;
      for (int i = 0; i < 25; i++) begin
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check($sformatf("free%0d count", i), int'(count), (i + 1) % MODULUS);
        compare_model($sformatf("free%0d", i));
        if (wrap) n_wraps++;
      end
      check("free wrap total", n_wraps, 2);
    end

    // Enable gating: en toggles every other cycle, tc must hold through 9.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b0, 4'd0, logic'(i % 2), 1'b0);
      compare_model($sformatf("gate%0d", i));
    end

    // Async reset between edges while count is 5.
    step(1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
    check("pre_async count", int'(count), 5);
    #2;
    reset = 1'b1;
    #1;
    check("async count",    int'(count),    0);
    check("async tc",       int'(tc),       0);
    check("async wrap",     int'(wrap),     0);
    check("async ovf",      int'(ovf),      0);
    check("async load_err", int'(load_err), 0);
    #2;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      compare_model($sformatf("resume%0d", i));
    end

    // Randomized phase against the model.
    for (int i = 0; i < 400; i++) begin
      logic c, l, e, oc;
      logic [WIDTH-1:0] lv;
      c  = ($urandom_range(15) == 0);
      l  = ($urandom_range(7) == 0);
      e  = ($urandom_range(3) != 0);
      oc = ($urandom_range(7) == 0);
      lv = WIDTH'($urandom_range(15));
`ifdef UP_COUNTER_MOD_CMP_EN
      if ($urandom_range(15) == 0) cmp_val = WIDTH'($urandom_range(15));
      m_cmp_val = int'(cmp_val);
`endif
      step(c, l, lv, e, oc);
      compare_model($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
